modulo_controlador_display_bcd: RTL and testbench
=================================================

# modulo_controlador_display_bcd

Two-digit multiplexed seven-segment display controller. It sits directly downstream of the binary-to-BCD converter stage and consumes its 5-bit BCD word: one tens bit and one units nibble. It captures that word on a load strobe and time-multiplexes the two digits onto a shared active-low segment bus with per-digit active-low enables.

## Interface
- DIVISOR_REFRESCO, 50000: clock cycles each digit slot is held; legal range ≥2.
- ANCHO_CONTADOR, $clog2(DIVISOR_REFRESCO): prescaler width; derived, not overridden.
- reloj  input  1  single clock; all state is rising-edge triggered.
- reset  input  1  asynchronous, active-high reset.
- entradaBCD  input  5  [4] is the tens digit (0/1); [3:0] is the units digit (legal 0–9).
- entradaValida  input  1  load strobe; entradaBCD is captured on any edge where this is high.
- salidaSegmentos  output  7  {g,f,e,d,c,b,a}, active-low; reset value 7'b1111111.
- salidaAnodos  output  2  [1] tens, [0] units, active-low; reset value 2'b11.
- salidaError  output  1  high while the captured units nibble is >9; reset value 0.

## Operation
- **Data register:** 5 bits, reset value 0. It loads entradaBCD when entradaValida=1; otherwise it holds.
- **Error flag:** salidaError is registered with the load. It is set when the loaded [3:0] is >9 and cleared by the next load with [3:0] ≤9.
- **Prescaler:** counts 0..DIVISOR_REFRESCO-1 and wraps to 0. The tick is the cycle in which the count equals DIVISOR_REFRESCO-1.
- **FSM states:**
  - APAGADO is the reset state. Both anodes are inactive and all segments are off.
  - UNIDADES: salidaAnodos=2'b10, segments show the units digit.
  - DECENAS: salidaAnodos=2'b01, segments show the tens digit (0 or 1).
- **FSM transitions, on tick only:**
  - APAGADO→UNIDADES.
  - UNIDADES→DECENAS.
  - DECENAS→UNIDADES.
  - APAGADO is never re-entered except through reset.
- **Decode:**
  - Digits 0–9 use standard active-low patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - An illegal units nibble (10–15) shows a dash, 7'b0111111.
- **Outputs:** salidaSegmentos and salidaAnodos are registers. Each cycle they load the value decoded from the next FSM state and the current data register, so they are glitch-free and never show one digit's segments under the other digit's anode.
- **Simultaneous load and tick:** both take effect. The state change appears at that edge using the old data; the new data appears one edge later.
- **Reset mid-operation:** outputs return immediately to their reset values; the data register, error flag, prescaler and FSM are cleared.

## Timing
- After reset deasserts, the first tick occurs DIVISOR_REFRESCO edges later. Outputs leave APAGADO on that edge, showing the units slot.
- Load latency: entradaValida high at edge N means new segments are visible after edge N+1, inside the current slot; the block does not wait for a slot boundary.
- salidaError is valid after edge N, one cycle before the segments change.
- Full scan period is 2·DIVISOR_REFRESCO cycles with a 50% duty per digit.
- There is no dead cycle between slots; the anodes switch on the tick edge.

## Configuration
- SUPRESION_CEROS_EN
  - Defined: in DECENAS with tens bit 0, salidaAnodos=2'b11 and salidaSegmentos=7'b1111111 (leading-zero blanking). Slot timing is unchanged.
  - Undefined: the tens digit always displays, so 0 appears as "0".
  - salidaError behaviour is identical in both builds.

## Structure
- **Package paqueteDisplay:**
  - the FSM state enum (APAGADO, UNIDADES, DECENAS);
  - segment constants SEG_APAGADO=7'b1111111 and SEG_GUION=7'b0111111;
  - anode constants for units, tens and none.
- **Sub-module moduloDecodificadorSieteSegmentos:** purely combinational, 4-bit in, 7-bit active-low out, dash for 10–15. It is instantiated once, fed by a mux of the selected digit.

## Test plan
Run all scenarios with DIVISOR_REFRESCO=4.
- Reset held 3 cycles then released → segments 7'b1111111, anodes 2'b11, error 0 until edge 4. Then anodes 2'b10 showing 0 (7'b1000000).
- Load 5'b1_0111 (17) pulse → units slot shows 7 (7'b1111000) after the next edge. The next tick gives anodes 2'b01 with 1 (7'b1111001), and slots alternate every 4 cycles.
- Load 5'b0_1100 → error=1 one edge after the load and units show 7'b0111111. Then load 5'b0_0011 → error=0 and units show 3 (7'b0110000).
- Load 5'b0_0100 and observe the DECENAS slot:
  - with SUPRESION_CEROS_EN, anodes 2'b11 and segments off;
  - without it, anodes 2'b01 and segments 7'b1000000.
- Assert entradaValida on the tick cycle with 5'b1_1001 → the anode switch occurs at that edge and the new digits appear one edge later. Check that no cycle drives two anodes low.
- Assert reset asynchronously mid-slot in DECENAS → outputs go to 2'b11/7'b1111111 before the next edge, and the sequence restarts from APAGADO with data 0.

Source files
------------

// File: rtl/modulo_controlador_display_bcd_pkg.sv
// paqueteDisplay: shared types and constants for the two-digit display
// controller.
//   - estado_t:  scan FSM states (APAGADO, UNIDADES, DECENAS)
//   - SEG_*:     active-low segment patterns {g,f,e,d,c,b,a}
//   - ANODO_*:   active-low anode enables, [1] tens, [0] units
package paqueteDisplay;

    typedef enum logic [1:0] {
        APAGADO  = 2'd0,
        UNIDADES = 2'd1,
        DECENAS  = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_GUION   = 7'b0111111;

    localparam logic [1:0] ANODO_UNIDADES = 2'b10;
    localparam logic [1:0] ANODO_DECENAS  = 2'b01;
    localparam logic [1:0] ANODO_NINGUNO  = 2'b11;

endpackage

// File: rtl/modulo_controlador_display_bcd_decodificador.sv
// moduloDecodificadorSieteSegmentos: combinational BCD to seven-segment
// decoder with active-low outputs.
//   digito     in  4  digit value; 10..15 are illegal and shown as a dash
//   segmentos  out 7  {g,f,e,d,c,b,a}, active-low
module moduloDecodificadorSieteSegmentos
    import paqueteDisplay::*;
(
    input  logic [3:0] digito,
    output logic [6:0] segmentos
);

    always_comb begin
        segmentos = SEG_GUION;
        case (digito)
            4'd0: segmentos = 7'b1000000;
            4'd1: segmentos = 7'b1111001;
            4'd2: segmentos = 7'b0100100;
            4'd3: segmentos = 7'b0110000;
            4'd4: segmentos = 7'b0011001;
            4'd5: segmentos = 7'b0010010;
            4'd6: segmentos = 7'b0000010;
            4'd7: segmentos = 7'b1111000;
            4'd8: segmentos = 7'b0000000;
            4'd9: segmentos = 7'b0010000;
            default: segmentos = SEG_GUION;
        endcase
    end

endmodule

// File: rtl/modulo_controlador_display_bcd.sv
// modulo_controlador_display_bcd: two-digit multiplexed seven-segment
// controller. Captures a 5-bit BCD word on a load strobe and alternates the
// units and tens digits on a shared active-low segment bus.
//   reloj            in  1  clock, rising edge
//   reset            in  1  asynchronous, active-high
//   entradaBCD       in  5  [4] tens digit (0/1), [3:0] units digit
//   entradaValida    in  1  load strobe for entradaBCD
//   salidaSegmentos  out 7  {g,f,e,d,c,b,a}, active-low, registered
//   salidaAnodos     out 2  [1] tens, [0] units, active-low, registered
//   salidaError      out 1  captured units nibble is > 9
// Build option: define SUPRESION_CEROS_EN to blank the tens slot when the
// tens digit is 0 (slot timing is unchanged).
module modulo_controlador_display_bcd
    import paqueteDisplay::*;
#(
    parameter int unsigned DIVISOR_REFRESCO = 50000
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [4:0] entradaBCD,
    input  logic       entradaValida,
    output logic [6:0] salidaSegmentos,
    output logic [1:0] salidaAnodos,
    output logic       salidaError
);

    localparam int unsigned ANCHO_CONTADOR = $clog2(DIVISOR_REFRESCO);
    localparam logic [ANCHO_CONTADOR-1:0] CUENTA_MAX =
        ANCHO_CONTADOR'(DIVISOR_REFRESCO - 1);

    logic [4:0]                dato;
    logic [ANCHO_CONTADOR-1:0] contador;
    logic                      tick;
    estado_t                   estado;
    estado_t                   estado_sig;
    logic [3:0]                digito_sel;
    logic [6:0]                seg_decodificado;
    logic [6:0]                seg_sig;
    logic [1:0]                anodo_sig;

    // Data register and error flag share the load strobe.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            dato        <= '0;
            salidaError <= 1'b0;
        end else if (entradaValida) begin
            dato        <= entradaBCD;
            salidaError <= (entradaBCD[3:0] > 4'd9);
        end
    end

    // Slot prescaler.
    assign tick = (contador == CUENTA_MAX);

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            contador <= '0;
        end else if (tick) begin
            contador <= '0;
        end else begin
            contador <= contador + ANCHO_CONTADOR'(1);
        end
    end

    // Scan FSM state register.
    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            estado <= APAGADO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next state, and digit selection for the state being entered.
    always_comb begin
        estado_sig = estado;
        if (tick) begin
            case (estado)
                APAGADO:  estado_sig = UNIDADES;
                UNIDADES: estado_sig = DECENAS;
                DECENAS:  estado_sig = UNIDADES;
                default:  estado_sig = APAGADO;
            endcase
        end
        digito_sel = (estado_sig == DECENAS) ? {3'b000, dato[4]} : dato[3:0];
    end

    moduloDecodificadorSieteSegmentos u_decodificador (
        .digito    (digito_sel),
        .segmentos (seg_decodificado)
    );

    // Outputs are decoded from the next state so the registered segments and
    // anodes always switch together on the same edge.
    always_comb begin
        seg_sig   = SEG_APAGADO;
        anodo_sig = ANODO_NINGUNO;
        case (estado_sig)
            UNIDADES: begin
                seg_sig   = seg_decodificado;
                anodo_sig = ANODO_UNIDADES;
            end
            DECENAS: begin
`ifdef SUPRESION_CEROS_EN
                if (dato[4]) begin
                    seg_sig   = seg_decodificado;
                    anodo_sig = ANODO_DECENAS;
                end
`else
                seg_sig   = seg_decodificado;
                anodo_sig = ANODO_DECENAS;
`endif
            end
            default: begin
                seg_sig   = SEG_APAGADO;
                anodo_sig = ANODO_NINGUNO;
            end
        endcase
    end

    always_ff @(posedge reloj or posedge reset) begin
        if (reset) begin
            salidaSegmentos <= SEG_APAGADO;
            salidaAnodos    <= ANODO_NINGUNO;
        end else begin
            salidaSegmentos <= seg_sig;
            salidaAnodos    <= anodo_sig;
        end
    end

endmodule

// File: tb/tb_modulo_controlador_display_bcd.sv
// Self-checking bench for modulo_controlador_display_bcd with a slot length
// of 4 cycles. The reference model derives the displayed slot from the number
// of edges since reset and the shown data from the loads seen so far.
module tb_modulo_controlador_display_bcd;

    localparam int D = 4;

    logic       reloj = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] entradaBCD = '0;
    logic       entradaValida = 1'b0;
    logic [6:0] salidaSegmentos;
    logic [1:0] salidaAnodos;
    logic       salidaError;

    modulo_controlador_display_bcd #(.DIVISOR_REFRESCO(D)) dut (
        .reloj           (reloj),
        .reset           (reset),
        .entradaBCD      (entradaBCD),
        .entradaValida   (entradaValida),
        .salidaSegmentos (salidaSegmentos),
        .salidaAnodos    (salidaAnodos),
        .salidaError     (salidaError)
    );

    always #5 reloj = ~reloj;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       err;
    } esperado_t;

    esperado_t cola[$];
    esperado_t mon_x;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int         edges  = 0;
    logic [4:0] dato_m = '0;
    logic       err_m  = 1'b0;

    logic [6:0] patrones [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] patron(input logic [3:0] d);
        if (d > 4'd9) return 7'b0111111;
        return patrones[d];
    endfunction

    function automatic bit en_decenas(input int e);
        return (e >= D) && ((((e - D) / D) % 2) == 1);
    endfunction

    // Expected outputs after edge e since reset, given the data that was
    // registered before that edge.
    function automatic esperado_t modelo_salida(input int e, input logic [4:0] d);
        esperado_t x;
        x.err = 1'b0;
        if (e < D) begin
            x.seg = 7'b1111111;
            x.an  = 2'b11;
        end else if (!en_decenas(e)) begin
            x.seg = patron(d[3:0]);
            x.an  = 2'b10;
        end else begin
`ifdef SUPRESION_CEROS_EN
            if (d[4]) begin
                x.seg = patron({3'b000, d[4]});
                x.an  = 2'b01;
            end else begin
                x.seg = 7'b1111111;
                x.an  = 2'b11;
            end
`else
            x.seg = patron({3'b000, d[4]});
            x.an  = 2'b01;
`endif
        end
        return x;
    endfunction

    task automatic check(input string nombre, input logic [31:0] actual,
                         input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nombre, $time, actual, esperado);
        end
    endtask

    // One clock cycle of stimulus; the expected response for the coming edge
    // is queued for the monitor.
    task automatic step(input logic rst_in, input logic v, input logic [4:0] b);
        esperado_t x;
        @(negedge reloj);
        reset         = rst_in;
        entradaValida = v;
        entradaBCD    = b;
        if (rst_in) begin
            edges  = 0;
            dato_m = '0;
            err_m  = 1'b0;
            x      = '{seg: 7'b1111111, an: 2'b11, err: 1'b0};
        end else begin
            edges++;
            x = modelo_salida(edges, dato_m);
            if (v) begin
                dato_m = b;
                err_m  = (b[3:0] > 4'd9);
            end
            x.err = err_m;
        end
        cola.push_back(x);
        @(posedge reloj);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0);
    endtask

    // Monitor: one queued expectation per clock edge.
    always @(posedge reloj) begin
        #1;
        if (cola.size() > 0) begin
            mon_x = cola.pop_front();
            check("segmentos", 32'(salidaSegmentos), 32'(mon_x.seg));
            check("anodos", 32'(salidaAnodos), 32'(mon_x.an));
            check("error", 32'(salidaError), 32'(mon_x.err));
            check("dos_anodos_activos", 32'(salidaAnodos == 2'b00), 32'd0);
        end
    end

    initial begin
        bit encontrado;

        // Reset held 3 cycles, then the off period and first units slot.
        repeat (3) step(1'b1, 1'b0, 5'd0);
        idle(6);

        // 17: units 7, tens 1.
        step(1'b0, 1'b1, 5'b10111);
        idle(10);

        // Illegal units nibble then a legal one.
        step(1'b0, 1'b1, 5'b01100);
        idle(3);
        step(1'b0, 1'b1, 5'b00011);
        idle(3);

        // Tens digit 0 through a full scan.
        step(1'b0, 1'b1, 5'b00100);
        idle(3 * D);

        // Load on a tick cycle.
        for (int i = 0; i < D; i++) begin
            if (((edges + 1 - D) % D) == 0) break;
            idle(1);
        end
        step(1'b0, 1'b1, 5'b11001);
        idle(2 * D + 2);

        // Random loads, including illegal nibbles.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 3) == 0), 5'($urandom));
        end

        // Asynchronous reset in the middle of a tens slot.
        step(1'b0, 1'b1, 5'b10010);
        encontrado = 1'b0;
        for (int i = 0; i < 4 * D; i++) begin
            idle(1);
            if (en_decenas(edges)) begin
                encontrado = 1'b1;
                break;
            end
        end
        check("alcanza_decenas", 32'(encontrado), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("reset_async_segmentos", 32'(salidaSegmentos), 32'h7F);
        check("reset_async_anodos", 32'(salidaAnodos), 32'h3);
        check("reset_async_error", 32'(salidaError), 32'd0);
        repeat (2) step(1'b1, 1'b0, 5'd0);
        idle(3 * D);

        @(posedge reloj);
        #2;
        check("cola_vacia", 32'(cola.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
